// File: rtl/present_dec_loader.sv
// present_dec_loader
//   Feeds a PRESENT decryption core. A byte stream is packed into 64-bit
//   ciphertext blocks, the round key is held in a register, and the core is
//   primed, run and read through its Enable/Done interface. The plaintext is
//   presented on a valid/ready output. One ciphertext block can be buffered
//   while the core is busy with the previous one.
//
// Ports
//   Clock, Reset        system clock; synchronous active-high reset
//   key_valid/ready     key handshake, key_data is the new key
//   in_valid/ready      ciphertext word handshake, in_data most-significant word first
//   out_valid/ready     plaintext handshake, out_data is the plaintext block
//   core_key            registered key to the core (orig_key)
//   core_ciphertext     registered ciphertext to the core
//   core_enable         core Enable (low = load, high = run)
//   core_done           core Done
//   core_plaintext      core plaintext result
//   busy                core sequencer is not idle
//   dbg_state           current sequencer state (C_IDLE=0 .. C_OUT=4)
//
// Handshake rule (all three interfaces): a transfer happens on a rising Clock
// edge where valid and ready are both high. A source holds valid and data
// steady until that transfer; ready may be asserted independently of valid.
module present_dec_loader #(
  parameter int BLOCK_W       = 64,
  parameter int KEY_W         = 80,
  parameter int IN_W          = 8,
  parameter int CAPTURE_DELAY = 1
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               key_valid,
  output logic               key_ready,
  input  logic [KEY_W-1:0]   key_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic [KEY_W-1:0]   core_key,
  output logic [BLOCK_W-1:0] core_ciphertext,
  output logic               core_enable,
  input  logic               core_done,
  input  logic [BLOCK_W-1:0] core_plaintext,
  output logic               busy,
  output logic [2:0]         dbg_state
);

  localparam int WORDS = BLOCK_W / IN_W;
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);
  localparam logic [1:0] DLY_INIT = 2'(CAPTURE_DELAY);

  typedef enum logic [2:0] {
    C_IDLE  = 3'd0,
    C_PRIME = 3'd1,
    C_RUN   = 3'd2,
    C_CAP   = 3'd3,
    C_OUT   = 3'd4
  } state_t;

  state_t state, state_nx;

  logic [BLOCK_W-1:0] shreg;
  logic [CNT_W-1:0]   word_cnt;
  logic               buf_full;
  logic               key_loaded;
  logic [1:0]         dly;

  logic key_hs, in_hs;
  logic launch, capture, load_dly, out_hs;

  // The key may only change while the core is idle, so key_ready tracks C_IDLE.
  assign key_ready = (state == C_IDLE);
  assign in_ready  = ~buf_full;
  assign busy      = (state != C_IDLE);
  assign dbg_state = state;

  assign key_hs = key_valid & key_ready;
  assign in_hs  = in_valid & in_ready;

  always_comb begin
    state_nx = state;
    launch   = 1'b0;
    capture  = 1'b0;
    load_dly = 1'b0;
    out_hs   = 1'b0;
    unique case (state)
      C_IDLE: begin
        // A key arriving this cycle wins; the block launches next cycle with it.
        if (buf_full && key_loaded && !key_hs) begin
          launch   = 1'b1;
          state_nx = C_PRIME;
        end
      end
      C_PRIME: state_nx = C_RUN;
      C_RUN: begin
        if (core_done) begin
          if (CAPTURE_DELAY == 0) begin
            capture  = 1'b1;
            state_nx = C_OUT;
          end else begin
            load_dly = 1'b1;
            state_nx = C_CAP;
          end
        end
      end
      C_CAP: begin
        if (dly == 2'd0) begin
          capture  = 1'b1;
          state_nx = C_OUT;
        end
      end
      C_OUT: begin
        if (out_ready) begin
          out_hs   = 1'b1;
          state_nx = C_IDLE;
        end
      end
      default: state_nx = C_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) state <= C_IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      shreg           <= '0;
      word_cnt        <= '0;
      buf_full        <= 1'b0;
      key_loaded      <= 1'b0;
      core_key        <= '0;
      core_ciphertext <= '0;
      core_enable     <= 1'b0;
      dly             <= 2'd0;
      out_data        <= '0;
      out_valid       <= 1'b0;
    end else begin
      if (key_hs) begin
        core_key   <= key_data;
        key_loaded <= 1'b1;
      end

      // in_ready is low while buf_full, so a new word never meets a launch.
      if (in_hs) begin
        shreg <= (shreg << IN_W) | BLOCK_W'(in_data);
        if (word_cnt == LAST_WORD) begin
          word_cnt <= '0;
          buf_full <= 1'b1;
        end else begin
          word_cnt <= word_cnt + 1'b1;
        end
      end

      if (launch) begin
        core_ciphertext <= shreg;
        buf_full        <= 1'b0;
      end

      // Enable stays low through C_PRIME so the core reloads its state.
      if (state == C_PRIME) core_enable <= 1'b1;

      if (load_dly)                         dly <= DLY_INIT;
      else if (state == C_CAP && dly != 0)  dly <= dly - 1'b1;

      if (capture) begin
        out_data    <= core_plaintext;
        out_valid   <= 1'b1;
        core_enable <= 1'b0;
      end

      if (out_hs) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_present_dec_loader.sv
module tb_present_dec_loader;

  localparam int CAP = 1;

  logic        Clock;
  logic        Reset;
  logic        key_valid;
  logic        key_ready;
  logic [79:0] key_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [79:0] core_key;
  logic [63:0] core_ciphertext;
  logic        core_enable;
  logic        core_done;
  logic [63:0] core_plaintext;
  logic        busy;
  logic [2:0]  dbg_state;

  present_dec_loader #(
    .BLOCK_W(64), .KEY_W(80), .IN_W(8), .CAPTURE_DELAY(CAP)
  ) dut (
    .Clock(Clock), .Reset(Reset),
    .key_valid(key_valid), .key_ready(key_ready), .key_data(key_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .core_key(core_key), .core_ciphertext(core_ciphertext),
    .core_enable(core_enable), .core_done(core_done),
    .core_plaintext(core_plaintext), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- counters / scoreboard ----------------
  int n_checks = 0;
  int n_errs   = 0;
  logic [63:0] exp_q[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic note_timeout(input string nm);
    n_checks++;
    n_errs++;
    $display("FAIL %s: got timeout expected event", nm);
  endtask

  // ---------------- PRESENT-80 reference ----------------
  logic [3:0] sbox_t [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                              4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    logic [3:0] r;
    r = 4'h0;
    for (int y = 0; y < 16; y++) if (sbox_t[y] == x) r = 4'(y);
    return r;
  endfunction

  function automatic logic [63:0] present_dec(input logic [63:0] ct, input logic [79:0] key);
    logic [63:0] rk [1:32];
    logic [79:0] k;
    logic [63:0] s, t;
    k = key;
    for (int i = 1; i <= 32; i++) begin
      rk[i] = k[79:16];
      if (i < 32) begin
        k = {k[18:0], k[79:19]};
        k[79:76] = sbox_t[k[79:76]];
        k[19:15] = k[19:15] ^ 5'(i);
      end
    end
    s = ct ^ rk[32];
    for (int r = 31; r >= 1; r--) begin
      for (int i = 0; i < 64; i++) t[i] = s[(i == 63) ? 63 : (i * 16) % 63];
      for (int n = 0; n < 16; n++) t[n*4 +: 4] = inv_sbox(t[n*4 +: 4]);
      s = t ^ rk[r];
    end
    return s;
  endfunction

  // ---------------- core model ----------------
  int          cyc = 0;
  int          run_cnt = 0;
  int          core_lat = 1;
  int          done_edge = 0;
  logic        done_seen = 1'b0;
  logic        run_done = 1'b0;
  logic        spur = 1'b0;
  logic [63:0] ld_pt = '0;
  logic [79:0] ld_key = '0;
  logic [63:0] garbage = '0;

  // Done while Enable is low is random noise; the loader must ignore it.
  assign core_done      = core_enable ? run_done : spur;
  assign core_plaintext = (core_enable && run_done) ? ld_pt : garbage;

  always @(posedge Clock) begin
    cyc     <= cyc + 1;
    spur    <= ($urandom_range(0, 3) == 0);
    garbage <= {$urandom, $urandom};
    if (!core_enable) begin
      run_cnt   <= 0;
      run_done  <= 1'b0;
      done_seen <= 1'b0;
      ld_key    <= core_key;
      ld_pt     <= present_dec(core_ciphertext, core_key);
      core_lat  <= $urandom_range(1, 6);
    end else begin
      run_cnt <= run_cnt + 1;
      if (run_cnt + 1 >= core_lat) run_done <= 1'b1;
      if (core_done && !done_seen) begin
        done_seen <= 1'b1;
        done_edge <= cyc;
      end
      chk("core_key_stable_in_run", core_key, ld_key);
    end
  end

  // ---------------- monitor ----------------
  logic        prev_ov = 1'b0;
  logic        prev_en = 1'b0;
  logic [63:0] held = '0;
  logic [63:0] exp_v;
  int          en_rise = -1;
  int          hs_edge = -1;

  always @(posedge Clock) if (out_valid && out_ready) hs_edge <= cyc;

  always @(negedge Clock) begin
    if (out_valid && !prev_ov) begin
      if (exp_q.size() == 0) begin
        note_timeout("unexpected_output");
      end else begin
        exp_v = exp_q.pop_front();
        chk("out_data", out_data, exp_v);
      end
      chk("out_valid_latency", cyc - 1, done_edge + CAP + 1);
      held = out_data;
    end else if (out_valid && prev_ov) begin
      chk("out_data_stable", out_data, held);
    end
    prev_ov = out_valid;
    if (core_enable) begin
      chk("key_ready_low_in_run", key_ready, 1'b0);
      chk("busy_in_run", busy, 1'b1);
    end
    if (core_enable && !prev_en) en_rise = cyc - 1;
    prev_en = core_enable;
  end

  // ---------------- drivers ----------------
  int ready_mode = 0;
  int last_acc = 0;
  int key_edge = 0;
  logic [79:0] cur_key = '0;

  always @(posedge Clock) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 2) == 0);
    endcase
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && t < 1000) begin tick(); t++; end
    if (t >= 1000) note_timeout("in_accept");
    tick();
    last_acc = cyc - 1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic send_block(input logic [63:0] ct, input int gap_max);
    for (int k = 7; k >= 0; k--) begin
      repeat ($urandom_range(0, gap_max)) tick();
      send_word(ct[k*8 +: 8]);
    end
  endtask

  task automatic load_key(input logic [79:0] k);
    int t;
    t = 0;
    key_valid = 1'b1;
    key_data  = k;
    while (!key_ready && t < 1000) begin tick(); t++; end
    if (t >= 1000) note_timeout("key_accept");
    tick();
    key_edge  = cyc - 1;
    key_valid = 1'b0;
  endtask

  task automatic wait_en(input string nm, output int e);
    int t;
    t = 0;
    while (en_rise < 0 && t < 500) begin tick(); t++; end
    if (t >= 500) note_timeout(nm);
    e = en_rise;
  endtask

  task automatic wait_out_valid();
    int t;
    t = 0;
    while (!out_valid && t < 500) begin tick(); t++; end
    if (t >= 500) note_timeout("wait_out_valid");
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy || out_valid) && t < 3000) begin tick(); t++; end
    if (t >= 3000) note_timeout("drain");
  endtask

  task automatic reset_pulse();
    Reset     = 1'b1;
    in_valid  = 1'b0;
    key_valid = 1'b0;
    tick();
    Reset = 1'b0;
    exp_q.delete();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 64'h0);
    chk("rst_core_enable", core_enable, 1'b0);
    chk("rst_core_ciphertext", core_ciphertext, 64'h0);
    chk("rst_core_key", core_key, 80'h0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_key_ready", key_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
  endtask

  // ---------------- test sequence ----------------
  localparam logic [79:0] KEY_F = {80{1'b1}};
  int e;

  initial begin
    Reset = 1'b1; key_valid = 1'b0; key_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge Clock);
    reset_pulse();

    // 1: zero key, known vector, output held while out_ready low
    ready_mode = 0;
    load_key(80'h0);
    en_rise = -1;
    send_block(64'h5579C1387B228445, 0);
    exp_q.push_back(64'h0);
    wait_en("t1_enable", e);
    chk("t1_enable_latency", e, last_acc + 2);
    wait_out_valid();
    repeat (5) tick();
    chk("t1_out_valid_held", out_valid, 1'b1);
    chk("t1_out_data_held", out_data, 64'h0);
    ready_mode = 1;
    drain();

    // 2: all-ones key, then a key offered during the run lands only in idle
    load_key(KEY_F);
    en_rise = -1;
    send_block(64'hE72C46C0F5945049, 1);
    exp_q.push_back(64'h0);
    wait_en("t2_enable", e);
    key_valid = 1'b1;
    key_data  = 80'h0;
    #1;
    chk("t2_key_ready_busy", key_ready, 1'b0);
    load_key(80'h0);
    chk("t2_key_after_out", key_edge, hs_edge + 1);
    chk("t2_core_key", core_key, 80'h0);
    send_block(64'hA112FFC72F68417B, 1);
    exp_q.push_back(64'hFFFFFFFFFFFFFFFF);
    drain();

    // 3: back-to-back with the second block buffered
    ready_mode = 0;
    load_key(KEY_F);
    send_block(64'hE72C46C0F5945049, 0);
    exp_q.push_back(64'h0);
    send_block(64'h3333DCD3213210D2, 0);
    exp_q.push_back(64'hFFFFFFFFFFFFFFFF);
    chk("t3_in_ready_stall", in_ready, 1'b0);
    wait_out_valid();
    repeat (3) tick();
    chk("t3_in_ready_still", in_ready, 1'b0);
    en_rise = -1;
    ready_mode = 1;
    wait_en("t3_enable", e);
    chk("t3_gap", e, hs_edge + 2);
    drain();

    // 4: ciphertext before key
    reset_pulse();
    send_block(64'h3333DCD3213210D2, 0);
    exp_q.push_back(64'hFFFFFFFFFFFFFFFF);
    repeat (5) tick();
    chk("t4_busy", busy, 1'b0);
    chk("t4_core_enable", core_enable, 1'b0);
    chk("t4_buf_full", in_ready, 1'b0);
    en_rise = -1;
    load_key(KEY_F);
    wait_en("t4_enable", e);
    chk("t4_start_after_key", e, key_edge + 2);
    drain();

    // 5: reset mid-run and mid-block
    load_key(80'h0);
    send_block(64'hA112FFC72F68417B, 0);
    exp_q.push_back(64'hFFFFFFFFFFFFFFFF);
    begin
      int t;
      t = 0;
      while (!core_enable && t < 100) begin tick(); t++; end
      if (t >= 100) note_timeout("t5_run");
    end
    reset_pulse();
    load_key(80'h0);
    for (int k = 7; k >= 3; k--) send_word(8'(64'h0123456789ABCDEF >> (k * 8)));
    reset_pulse();
    load_key(80'h0);
    send_block(64'h5579C1387B228445, 2);
    exp_q.push_back(64'h0);
    drain();

    // 6: random keys, blocks, gaps and back-pressure
    for (int b = 0; b < 4; b++) begin
      cur_key = {$urandom, $urandom, 16'($urandom)};
      load_key(cur_key);
      ready_mode = 0;
      fork
        begin
          repeat (10) @(posedge Clock);
          ready_mode = 2;
        end
      join_none
      for (int n = 0; n < 5; n++) begin
        logic [63:0] ct;
        ct = {$urandom, $urandom};
        send_block(ct, 3);
        exp_q.push_back(present_dec(ct, cur_key));
      end
      drain();
    end

    chk("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
